// File: rtl/alu_hilo.sv
// alu_hilo: iterative multiply/divide unit that owns the HI/LO registers.
// It runs MULT/MULTU/DIV/DIVU over 32 iterations and writes MTHI/MTLO in one cycle.
// Ports:
//   clk, rst          clock (rising edge) and asynchronous active-low reset
//   op_valid, op      op request: 0 NOP, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 NOP
//   src_a, src_b      rs / rt operands
//   flush             abort the in-flight op and drop any op presented this cycle
//   busy              unit occupied (decoded from the state register)
//   done              one-cycle pulse after the HI/LO result write
//   hi, lo            HI/LO registers
module alu_hilo (
    input  logic        clk,
    input  logic        rst,
    input  logic        op_valid,
    input  logic [2:0]  op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic        flush,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int unsigned W  = 32;
    localparam int unsigned CW = 5;
    localparam logic [CW-1:0] LAST_ITER = CW'(W - 1);

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_CALC   = 2'd1,
        S_FINISH = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [CW-1:0]       counter_q, counter_d;
    logic [2*W-1:0]      acc_q, acc_d;       // mult: {partial, multiplier}; div: {remainder, quotient}
    logic [W-1:0]        opnd_q, opnd_d;     // multiplicand or divisor magnitude
    logic [W-1:0]        raw_a_q, raw_a_d;   // unmodified dividend, returned in HI on divide by zero
    logic                is_div_q, is_div_d;
    logic                res_neg_q, res_neg_d;
    logic                dvd_neg_q, dvd_neg_d;
    logic                div_zero_q, div_zero_d;
    logic [W-1:0]        hi_q, hi_d;
    logic [W-1:0]        lo_q, lo_d;
    logic                done_q, done_d;

    logic                accept_c;
    logic                start_md_c;
    logic                signed_op_c;
    logic                a_neg_c;
    logic                b_neg_c;
    logic [W-1:0]        mag_a_c;
    logic [W-1:0]        mag_b_c;
    logic [W:0]          mult_sum_c;
    logic [2*W:0]        div_shift_c;
    logic [W+1:0]        div_diff_c;
    logic [2*W-1:0]      prod_c;
    logic [W-1:0]        quot_c;
    logic [W-1:0]        rem_c;

    assign hi   = hi_q;
    assign lo   = lo_q;
    assign done = done_q;

    // Request decode and operand magnitudes for the accept edge
    always_comb begin
        accept_c    = (state_q == S_IDLE) && op_valid && !flush;
        start_md_c  = accept_c && (op == OP_MULT || op == OP_MULTU ||
                                   op == OP_DIV  || op == OP_DIVU);
        signed_op_c = (op == OP_MULT) || (op == OP_DIV);
        a_neg_c     = signed_op_c && src_a[W-1];
        b_neg_c     = signed_op_c && src_b[W-1];
        mag_a_c     = a_neg_c ? (~src_a + W'(1)) : src_a;
        mag_b_c     = b_neg_c ? (~src_b + W'(1)) : src_b;
    end

    // One iteration step for each algorithm, plus final sign correction
    always_comb begin
        mult_sum_c  = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, opnd_q} : (W+1)'(0));
        div_shift_c = {acc_q, 1'b0};
        div_diff_c  = {1'b0, div_shift_c[2*W:W]} - {2'b00, opnd_q};
        prod_c      = res_neg_q ? (~acc_q + (2*W)'(1)) : acc_q;
        quot_c      = res_neg_q ? (~acc_q[W-1:0] + W'(1)) : acc_q[W-1:0];
        rem_c       = dvd_neg_q ? (~acc_q[2*W-1:W] + W'(1)) : acc_q[2*W-1:W];
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; flush overrides everything
    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:   if (start_md_c) state_d = S_CALC;
                S_CALC:   if (counter_q == LAST_ITER) state_d = S_FINISH;
                S_FINISH: state_d = S_IDLE;
                default:  state_d = S_IDLE;
            endcase
        end
    end

    // FSM outputs
    always_comb begin
        busy = (state_q != S_IDLE);
    end

    // Datapath next-state
    always_comb begin
        counter_d  = counter_q;
        acc_d      = acc_q;
        opnd_d     = opnd_q;
        raw_a_d    = raw_a_q;
        is_div_d   = is_div_q;
        res_neg_d  = res_neg_q;
        dvd_neg_d  = dvd_neg_q;
        div_zero_d = div_zero_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        done_d     = 1'b0;

        if (flush) begin
            counter_d = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (accept_c && op == OP_MTHI) hi_d = src_a;
                    if (accept_c && op == OP_MTLO) lo_d = src_a;
                    if (start_md_c) begin
                        is_div_d   = (op == OP_DIV) || (op == OP_DIVU);
                        res_neg_d  = a_neg_c ^ b_neg_c;
                        dvd_neg_d  = a_neg_c;
                        div_zero_d = (src_b == '0);
                        raw_a_d    = src_a;
                        counter_d  = '0;
                        if ((op == OP_DIV) || (op == OP_DIVU)) begin
                            acc_d  = {{W{1'b0}}, mag_a_c};
                            opnd_d = mag_b_c;
                        end else begin
                            acc_d  = {{W{1'b0}}, mag_b_c};
                            opnd_d = mag_a_c;
                        end
                    end
                end
                S_CALC: begin
                    counter_d = counter_q + CW'(1);
                    if (is_div_q) begin
                        // Restoring step: keep the trial difference when it did not borrow
                        if (!div_diff_c[W+1]) begin
                            acc_d = {div_diff_c[W-1:0], div_shift_c[W-1:1], 1'b1};
                        end else begin
                            acc_d = div_shift_c[2*W-1:0];
                        end
                    end else begin
                        acc_d = {mult_sum_c, acc_q[W-1:1]};
                    end
                end
                S_FINISH: begin
                    counter_d = '0;
                    done_d    = 1'b1;
                    if (!is_div_q) begin
                        hi_d = prod_c[2*W-1:W];
                        lo_d = prod_c[W-1:0];
                    end else if (div_zero_q) begin
                        hi_d = raw_a_q;
                        lo_d = {W{1'b1}};
                    end else begin
                        hi_d = rem_c;
                        lo_d = quot_c;
                    end
                end
                default: counter_d = '0;
            endcase
        end
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            counter_q  <= '0;
            acc_q      <= '0;
            opnd_q     <= '0;
            raw_a_q    <= '0;
            is_div_q   <= 1'b0;
            res_neg_q  <= 1'b0;
            dvd_neg_q  <= 1'b0;
            div_zero_q <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
            done_q     <= 1'b0;
        end else begin
            counter_q  <= counter_d;
            acc_q      <= acc_d;
            opnd_q     <= opnd_d;
            raw_a_q    <= raw_a_d;
            is_div_q   <= is_div_d;
            res_neg_q  <= res_neg_d;
            dvd_neg_q  <= dvd_neg_d;
            div_zero_q <= div_zero_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            done_q     <= done_d;
        end
    end

endmodule

// File: tb/tb_alu_hilo.sv
// Directed testbench for alu_hilo: hand-computed HI/LO results, latency,
// done pulse, back-to-back accept, flush and asynchronous reset behaviour.
module tb_alu_hilo;

    logic        clk;
    logic        rst;
    logic        op_valid;
    logic [2:0]  op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        flush;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int errors;
    int checks;

    alu_hilo dut (
        .clk      (clk),
        .rst      (rst),
        .op_valid (op_valid),
        .op       (op),
        .src_a    (src_a),
        .src_b    (src_b),
        .flush    (flush),
        .busy     (busy),
        .done     (done),
        .hi       (hi),
        .lo       (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present one op for one edge; call at posedge+1, returns at posedge+1
    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        op_valid = 1'b1;
        op       = o;
        src_a    = a;
        src_b    = b;
        @(posedge clk);
        #1;
        op_valid = 1'b0;
        op       = 3'd0;
    endtask

    // Count busy cycles until idle, bounded
    task automatic wait_idle(output int cycles);
        cycles = 0;
        while (busy && cycles < 100) begin
            @(posedge clk);
            #1;
            cycles++;
        end
    endtask

    task automatic test_reset;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
        checks++; if (hi !== 32'h0) begin errors++; $display("FAIL reset_hi: got %h want 0", hi); end
        checks++; if (lo !== 32'h0) begin errors++; $display("FAIL reset_lo: got %h want 0", lo); end
        rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_multu;
        int cyc;
        issue(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL multu_busy_start: got %b want 1", busy); end
        wait_idle(cyc);
        checks++; if (cyc !== 33) begin errors++; $display("FAIL multu_busy_cycles: got %0d want 33", cyc); end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL multu_done: got %b want 1", done); end
        checks++; if (hi !== 32'hFFFF_FFFE) begin errors++; $display("FAIL multu_hi: got %h want fffffffe", hi); end
        checks++; if (lo !== 32'h0000_0001) begin errors++; $display("FAIL multu_lo: got %h want 00000001", lo); end
        @(posedge clk);
        #1;
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL multu_done_pulse: got %b want 0", done); end
    endtask

    task automatic test_back_to_back;
        int cyc;
        issue(3'd1, 32'hFFFF_FFFD, 32'h0000_0005);
        wait_idle(cyc);
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL mult_done: got %b want 1", done); end
        checks++; if (hi !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mult_hi: got %h want ffffffff", hi); end
        checks++; if (lo !== 32'hFFFF_FFF1) begin errors++; $display("FAIL mult_lo: got %h want fffffff1", lo); end
        // DIVU presented in the done cycle of the MULT
        issue(3'd4, 32'd100, 32'd7);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_accept: busy got %b want 1", busy); end
        wait_idle(cyc);
        checks++; if (cyc !== 33) begin errors++; $display("FAIL divu_cycles: got %0d want 33", cyc); end
        checks++; if (lo !== 32'h0000_000E) begin errors++; $display("FAIL divu_lo: got %h want 0000000e", lo); end
        checks++; if (hi !== 32'h0000_0002) begin errors++; $display("FAIL divu_hi: got %h want 00000002", hi); end
    endtask

    task automatic test_div_signed;
        int cyc;
        issue(3'd3, 32'hFFFF_FFF9, 32'h0000_0002);
        repeat (3) @(posedge clk);
        #1;
        // MTHI while busy must be ignored
        issue(3'd5, 32'h1111_1111, 32'h0);
        wait_idle(cyc);
        checks++; if (lo !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div_neg_lo: got %h want fffffffd", lo); end
        checks++; if (hi !== 32'hFFFF_FFFF) begin errors++; $display("FAIL div_neg_hi: got %h want ffffffff", hi); end
    endtask

    task automatic test_div_overflow;
        int cyc;
        issue(3'd3, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_idle(cyc);
        checks++; if (lo !== 32'h8000_0000) begin errors++; $display("FAIL div_ovf_lo: got %h want 80000000", lo); end
        checks++; if (hi !== 32'h0) begin errors++; $display("FAIL div_ovf_hi: got %h want 00000000", hi); end
    endtask

    task automatic test_div_zero;
        int cyc;
        issue(3'd4, 32'h1234_5678, 32'h0);
        wait_idle(cyc);
        checks++; if (cyc !== 33) begin errors++; $display("FAIL divz_cycles: got %0d want 33", cyc); end
        checks++; if (lo !== 32'hFFFF_FFFF) begin errors++; $display("FAIL divz_lo: got %h want ffffffff", lo); end
        checks++; if (hi !== 32'h1234_5678) begin errors++; $display("FAIL divz_hi: got %h want 12345678", hi); end
        // Signed divide by zero with negative dividend returns the raw dividend
        issue(3'd3, 32'hFFFF_FF00, 32'h0);
        wait_idle(cyc);
        checks++; if (lo !== 32'hFFFF_FFFF) begin errors++; $display("FAIL sdivz_lo: got %h want ffffffff", lo); end
        checks++; if (hi !== 32'hFFFF_FF00) begin errors++; $display("FAIL sdivz_hi: got %h want ffffff00", hi); end
    endtask

    task automatic test_mthi_mtlo;
        issue(3'd5, 32'hDEAD_BEEF, 32'h0);
        checks++; if (hi !== 32'hDEAD_BEEF) begin errors++; $display("FAIL mthi_hi: got %h want deadbeef", hi); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mthi_busy: got %b want 0", busy); end
        issue(3'd6, 32'h0BAD_F00D, 32'h0);
        checks++; if (lo !== 32'h0BAD_F00D) begin errors++; $display("FAIL mtlo_lo: got %h want 0badf00d", lo); end
        checks++; if (hi !== 32'hDEAD_BEEF) begin errors++; $display("FAIL mtlo_hi_kept: got %h want deadbeef", hi); end
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL mtlo_busy_done: got %b%b want 00", busy, done); end
    endtask

    task automatic test_flush;
        int seen_done;
        issue(3'd5, 32'hAAAA_AAAA, 32'h0);
        issue(3'd6, 32'h5555_5555, 32'h0);
        issue(3'd3, 32'd50, 32'd3);
        repeat (10) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flush_busy: got %b want 0", busy); end
        seen_done = 0;
        for (int i = 0; i < 40; i++) begin
            if (done) seen_done++;
            @(posedge clk);
            #1;
        end
        checks++; if (seen_done !== 0) begin errors++; $display("FAIL flush_no_done: got %0d pulses want 0", seen_done); end
        checks++; if (hi !== 32'hAAAA_AAAA) begin errors++; $display("FAIL flush_hi: got %h want aaaaaaaa", hi); end
        checks++; if (lo !== 32'h5555_5555) begin errors++; $display("FAIL flush_lo: got %h want 55555555", lo); end
    endtask

    task automatic test_flush_finish;
        issue(3'd3, 32'd50, 32'd3);
        repeat (32) @(posedge clk);
        #1;
        // Now in FINISH; flush suppresses the write
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL flush_fin_ctl: got busy=%b done=%b want 0 0", busy, done); end
        checks++; if (lo !== 32'h5555_5555) begin errors++; $display("FAIL flush_fin_lo: got %h want 55555555", lo); end
    endtask

    task automatic test_div_plain;
        int cyc;
        issue(3'd3, 32'd50, 32'd3);
        wait_idle(cyc);
        checks++; if (lo !== 32'd16 || hi !== 32'd2) begin errors++; $display("FAIL div50_3: got hi=%h lo=%h want 2 10", hi, lo); end
    endtask

    task automatic test_reset_mid;
        issue(3'd5, 32'hAAAA_AAAA, 32'h0);
        issue(3'd6, 32'h5555_5555, 32'h0);
        issue(3'd3, 32'd50, 32'd3);
        repeat (5) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        checks++; if (hi !== 32'h0) begin errors++; $display("FAIL rstmid_hi: got %h want 0", hi); end
        checks++; if (lo !== 32'h0) begin errors++; $display("FAIL rstmid_lo: got %h want 0", lo); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b want 0", busy); end
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_flush_mtlo;
        issue(3'd6, 32'h5555_5555, 32'h0);
        flush = 1'b1;
        issue(3'd6, 32'h1234_5678, 32'h0);
        flush = 1'b0;
        checks++; if (lo !== 32'h5555_5555) begin errors++; $display("FAIL flush_mtlo: got %h want 55555555", lo); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flush_mtlo_busy: got %b want 0", busy); end
    endtask

    initial begin
        errors   = 0;
        checks   = 0;
        rst      = 1'b0;
        op_valid = 1'b0;
        op       = 3'd0;
        src_a    = 32'h0;
        src_b    = 32'h0;
        flush    = 1'b0;
        @(posedge clk);
        #1;
        test_reset;
        test_multu;
        test_back_to_back;
        test_div_signed;
        test_div_overflow;
        test_div_zero;
        test_mthi_mtlo;
        test_flush;
        test_flush_finish;
        test_div_plain;
        test_reset_mid;
        test_flush_mtlo;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
